muldiv_sequencer: RTL and testbench

Iterative RV64M multiply/divide unit with its own controller, running beside the single-cycle execute ALU. It accepts one operation at a time through a start/busy/done handshake and holds the pipeline through a stall output. The controller FSM sequences a shift-add multiplier or shift-subtract divider over up to 64 cycles. It then applies the sign fixup, hi/lo selection and word-width sign extension.

---
 rtl/muldiv_sequencer_pkg.sv | 38 +++
 rtl/muldiv_sequencer_if.sv | 29 ++
 rtl/muldiv_operand_prep.sv | 68 ++++++
 rtl/muldiv_sequencer.sv | 156 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings and bundle types for the iterative RV64M multiply/divide unit.
// Imported by the operand-prep block, the handshake interface and the sequencer.
package muldiv_sequencer_pkg;

    localparam logic [2:0] MULDIV_OP_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_OP_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_OP_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_OP_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_OP_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_OP_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_OP_REM    = 3'b110;
    localparam logic [2:0] MULDIV_OP_REMU   = 3'b111;

    localparam logic [2:0] MULDIV_ST_IDLE  = 3'd0;
    localparam logic [2:0] MULDIV_ST_PREP  = 3'd1;
    localparam logic [2:0] MULDIV_ST_CALC  = 3'd2;
    localparam logic [2:0] MULDIV_ST_FIXUP = 3'd3;
    localparam logic [2:0] MULDIV_ST_DONE  = 3'd4;

    localparam logic [6:0] ITER_DWORD = 7'd64;
    localparam logic [6:0] ITER_WORD  = 7'd32;

    typedef struct packed {
        logic [63:0] ext1;
        logic [63:0] mag1;
        logic [63:0] mag2;
        logic        neg_lo;
        logic        neg_hi;
        logic        div_zero;
        logic        overflow;
        logic        illegal;
    } prep_t;

    function automatic logic [63:0] sext_word(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Start/busy/done handshake and operand/result bus of the multiply/divide unit.
// master drives requests (execute stage), slave is the sequencer.
interface muldiv_sequencer_if;
    import muldiv_sequencer_pkg::*;

    logic        start_in;
    logic [2:0]  funct3_in;
    logic        word_op_in;
    logic        flush_in;
    logic [63:0] rs1_value_in;
    logic [63:0] rs2_value_in;
    logic [63:0] result_out;
    logic        busy_out;
    logic        done_out;
    logic        stall_signal_out;

    modport master (
        output start_in, funct3_in, word_op_in, flush_in,
        output rs1_value_in, rs2_value_in,
        input  result_out, busy_out, done_out, stall_signal_out
    );

    modport slave (
        input  start_in, funct3_in, word_op_in, flush_in,
        input  rs1_value_in, rs2_value_in,
        output result_out, busy_out, done_out, stall_signal_out
    );

endinterface

// File: rtl/muldiv_operand_prep.sv
// Operand width extension, magnitudes, result sign flags and special-case
// detection; purely combinational on the latched request.
module muldiv_operand_prep
    import muldiv_sequencer_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        word_op,
    input  logic [63:0] rs1_value,
    input  logic [63:0] rs2_value,
    output prep_t       prep
);

    logic        is_div;
    logic        sext_w;
    logic        signed1;
    logic        signed2;
    logic        neg1;
    logic        neg2;
    logic [63:0] ext1;
    logic [63:0] ext2;
    logic [63:0] w_min;

    always_comb begin
        signed1 = 1'b0;
        signed2 = 1'b0;
        unique case (funct3)
            MULDIV_OP_MULH,
            MULDIV_OP_DIV,
            MULDIV_OP_REM: begin
                signed1 = 1'b1;
                signed2 = 1'b1;
            end
            MULDIV_OP_MULHSU: signed1 = 1'b1;
            default: ;
        endcase
    end

    assign is_div = funct3[2];
    assign sext_w = (funct3 == MULDIV_OP_MUL) |
                    (funct3 == MULDIV_OP_DIV) |
                    (funct3 == MULDIV_OP_REM);

    assign ext1 = !word_op ? rs1_value :
                  sext_w   ? sext_word(rs1_value[31:0]) :
                             {32'd0, rs1_value[31:0]};
    assign ext2 = !word_op ? rs2_value :
                  sext_w   ? sext_word(rs2_value[31:0]) :
                             {32'd0, rs2_value[31:0]};

    assign neg1 = signed1 & ext1[63];
    assign neg2 = signed2 & ext2[63];

    // Most negative value at the operating width, already sign-extended.
    assign w_min = word_op ? 64'hFFFF_FFFF_8000_0000
                           : 64'h8000_0000_0000_0000;

    assign prep.ext1     = ext1;
    assign prep.mag1     = neg1 ? -ext1 : ext1;
    assign prep.mag2     = neg2 ? -ext2 : ext2;
    assign prep.neg_lo   = neg1 ^ neg2;
    assign prep.neg_hi   = neg1;
    assign prep.div_zero = is_div & (ext2 == 64'd0);
    assign prep.overflow = is_div & ~funct3[0] &
                           (ext1 == w_min) & (&ext2);
    assign prep.illegal  = word_op & ~is_div &
                           (funct3[1:0] != 2'b00);

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV64M multiply/divide controller: one bit per cycle shift-add
// multiply or restoring divide, then sign fixup and hi/lo/W selection.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic              clk_in,
    input  logic              reset_n_in,
    muldiv_sequencer_if.slave bus
);

    logic [2:0]      state_q;
    logic [2:0]      funct3_q;
    logic            word_q;
    logic [XLEN-1:0] op1_q;
    logic [XLEN-1:0] op2_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] m_q;
    logic [6:0]      cnt_q;
    logic [XLEN-1:0] result_q;

    prep_t           prep;
    logic            is_div;
    logic            special;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   sh;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] hi_n;
    logic [XLEN-1:0] lo_n;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] res_n;

    muldiv_operand_prep u_prep (
        .funct3    (funct3_q),
        .word_op   (word_q),
        .rs1_value (op1_q),
        .rs2_value (op2_q),
        .prep      (prep)
    );

    assign is_div  = funct3_q[2];
    assign special = prep.div_zero | prep.overflow | prep.illegal;

    // One iteration: multiply shifts the product right through lo,
    // divide shifts the dividend left out of lo into the remainder.
    always_comb begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        sh   = {hi_q, lo_q[XLEN-1]};
        diff = sh - {1'b0, m_q};
        if (is_div) begin
            if (!diff[XLEN]) begin
                hi_n = diff[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_n = sh[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_n = sum[XLEN:1];
            lo_n = {sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Word multiplies stop after 32 shifts, leaving the low word in lo[63:32].
    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = prep.neg_lo ? -prod : prod;
        quo      = prep.neg_lo ? -lo_q : lo_q;
        rem      = prep.neg_hi ? -hi_q : hi_q;
        if (prep.illegal) begin
            raw = '0;
        end else if (prep.div_zero) begin
            raw = funct3_q[1] ? prep.ext1 : '1;
        end else if (prep.overflow) begin
            raw = funct3_q[1] ? '0 : prep.ext1;
        end else if (is_div) begin
            raw = funct3_q[1] ? rem : quo;
        end else if (funct3_q[1:0] == 2'b00) begin
            raw = word_q ? {32'd0, prod_fix[63:32]}
                         : prod_fix[XLEN-1:0];
        end else begin
            raw = prod_fix[2*XLEN-1:XLEN];
        end
        res_n = word_q ? sext_word(raw[31:0]) : raw;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q  <= MULDIV_ST_IDLE;
            funct3_q <= '0;
            word_q   <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (bus.flush_in) begin
            state_q <= MULDIV_ST_IDLE;
        end else begin
            unique case (state_q)
                MULDIV_ST_IDLE: begin
                    if (bus.start_in) begin
                        funct3_q <= bus.funct3_in;
                        word_q   <= bus.word_op_in;
                        op1_q    <= bus.rs1_value_in;
                        op2_q    <= bus.rs2_value_in;
                        state_q  <= MULDIV_ST_PREP;
                    end
                end
                MULDIV_ST_PREP: begin
                    hi_q  <= '0;
                    cnt_q <= word_q ? ITER_WORD : ITER_DWORD;
                    if (is_div) begin
                        lo_q <= word_q ? {prep.mag1[31:0], 32'd0}
                                       : prep.mag1;
                        m_q  <= prep.mag2;
                    end else begin
                        lo_q <= prep.mag2;
                        m_q  <= prep.mag1;
                    end
                    state_q <= special ? MULDIV_ST_FIXUP
                                       : MULDIV_ST_CALC;
                end
                MULDIV_ST_CALC: begin
                    hi_q  <= hi_n;
                    lo_q  <= lo_n;
                    cnt_q <= cnt_q - 7'd1;
                    if (cnt_q == 7'd1) begin
                        state_q <= MULDIV_ST_FIXUP;
                    end
                end
                MULDIV_ST_FIXUP: begin
                    result_q <= res_n;
                    state_q  <= MULDIV_ST_DONE;
                end
                default: state_q <= MULDIV_ST_IDLE;
            endcase
        end
    end

    assign bus.result_out       = result_q;
    assign bus.busy_out         = (state_q != MULDIV_ST_IDLE);
    assign bus.done_out         = (state_q == MULDIV_ST_DONE);
    assign bus.stall_signal_out =
        (bus.start_in & (state_q == MULDIV_ST_IDLE)) |
        (bus.busy_out & ~bus.done_out);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer against an arithmetic RV64M model,
// plus directed special cases, flush, reset and latency checks.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] last_exp = '0;

    muldiv_sequencer_if bus();

    muldiv_sequencer dut (
        .clk_in     (clk),
        .reset_n_in (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [2:0] f3,
        input logic w, input logic [63:0] a, input logic [63:0] b);
        logic signed [31:0] sa32, sb32;
        logic [31:0]        ua32, ub32, r32;
        logic signed [63:0] sa, sb;
        logic [127:0]       xa, xb, pp;
        logic [63:0]        r;
        ua32 = a[31:0]; ub32 = b[31:0];
        sa32 = a[31:0]; sb32 = b[31:0];
        sa = a; sb = b;
        if (w) begin
            case (f3)
                3'd0: r32 = ua32 * ub32;
                3'd4: if (ub32 == 0) r32 = '1;
                      else if (ua32 == 32'h8000_0000 && ub32 == '1) r32 = ua32;
                      else r32 = sa32 / sb32;
                3'd5: r32 = (ub32 == 0) ? '1 : ua32 / ub32;
                3'd6: if (ub32 == 0) r32 = ua32;
                      else if (ua32 == 32'h8000_0000 && ub32 == '1) r32 = 0;
                      else r32 = sa32 % sb32;
                3'd7: r32 = (ub32 == 0) ? ua32 : ua32 % ub32;
                default: return 64'd0;
            endcase
            return {{32{r32[31]}}, r32};
        end
        case (f3)
            3'd0: r = a * b;
            3'd1, 3'd2, 3'd3: begin
                xa = (f3 != 3'd3) ? {{64{a[63]}}, a} : {64'd0, a};
                xb = (f3 == 3'd1) ? {{64{b[63]}}, b} : {64'd0, b};
                pp = xa * xb;
                r  = pp[127:64];
            end
            3'd4: if (b == 0) r = '1;
                  else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
                  else r = sa / sb;
            3'd5: r = (b == 0) ? '1 : a / b;
            3'd6: if (b == 0) r = a;
                  else if (a == 64'h8000_0000_0000_0000 && b == '1) r = 0;
                  else r = sa % sb;
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] f3,
        input logic w, input logic [63:0] a, input logic [63:0] b);
        logic bz, ov;
        if (w && !f3[2] && f3 != 3'd0) return 3;
        if (f3[2]) begin
            bz = w ? (b[31:0] == 0) : (b == 0);
            ov = !f3[0] && (w ?
                 (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) :
                 (a == 64'h8000_0000_0000_0000 && b == '1));
            if (bz || ov) return 3;
        end
        return w ? 35 : 67;
    endfunction

    function automatic logic [63:0] rand_val();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'(32'h8000_0000);
            4: return 64'($urandom_range(0, 20));
            5: return {32'd0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input string tag);
        logic [63:0] exp;
        int          lat;
        int          edges;
        logic        bs_ok;
        exp = ref_model(f3, w, a, b);
        lat = ref_latency(f3, w, a, b);
        @(negedge clk);
        bus.funct3_in = f3; bus.word_op_in = w;
        bus.rs1_value_in = a; bus.rs2_value_in = b;
        bus.start_in = 1'b1;
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        edges = 1;
        bs_ok = 1'b1;
        while (!bus.done_out && edges < 200) begin
            bs_ok &= bus.busy_out & bus.stall_signal_out;
            bus.start_in     = 1'($urandom_range(0, 1));
            bus.funct3_in    = 3'($urandom_range(0, 7));
            bus.rs1_value_in = {$urandom, $urandom};
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_latency"}, 64'(edges), 64'(lat));
        check({tag, "_result"}, bus.result_out, exp);
        check({tag, "_busy_stall"}, 64'(bs_ok), 64'd1);
        check({tag, "_stall_in_done"}, 64'(bus.stall_signal_out), 64'd0);
        bus.start_in = 1'b1;
        bus.rs1_value_in = {$urandom, $urandom};
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        check({tag, "_done_pulse"}, 64'(bus.done_out), 64'd0);
        check({tag, "_start_in_done"}, 64'(bus.busy_out), 64'd0);
        check({tag, "_hold"}, bus.result_out, exp);
        last_exp = exp;
    endtask

    initial begin
        logic done_seen;
        logic [2:0] f3;
        logic       w;
        rst_n = 1'b0;
        bus.start_in = 1'b0; bus.funct3_in = '0; bus.word_op_in = 1'b0;
        bus.flush_in = 1'b0;
        bus.rs1_value_in = '0; bus.rs2_value_in = '0;
        #12;
        check("reset_result", bus.result_out, 64'd0);
        check("reset_busy", 64'(bus.busy_out), 64'd0);
        check("reset_done", 64'(bus.done_out), 64'd0);
        check("reset_stall", 64'(bus.stall_signal_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd0, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, "mul");
        run_op(3'd3, 0, '1, '1, "mulhu");
        run_op(3'd1, 0, '1, '1, "mulh");
        run_op(3'd2, 0, '1, '1, "mulhsu");
        run_op(3'd4, 0, -64'sd7, 64'd2, "div");
        run_op(3'd6, 0, -64'sd7, 64'd2, "rem");
        run_op(3'd5, 0, 64'd100, 64'd7, "divu");
        run_op(3'd7, 0, 64'd100, 64'd7, "remu");
        run_op(3'd5, 0, 64'd5, 64'd0, "divu_zero");
        run_op(3'd6, 0, 64'd5, 64'd0, "rem_zero");
        run_op(3'd4, 0, 64'h8000_0000_0000_0000, '1, "div_ovf");
        run_op(3'd6, 1, 64'h8000_0000, 64'hFFFF_FFFF, "remw_ovf");
        run_op(3'd4, 1, 64'h8000_0000, 64'd1, "divw");
        run_op(3'd0, 1, 64'h7FFF_FFFF, 64'd2, "mulw");
        run_op(3'd1, 1, 64'd9, 64'd9, "mulhw_illegal");

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            if (w && !f3[2] && $urandom_range(0, 3) != 0) f3 = 3'd0;
            run_op(f3, w, rand_val(), rand_val(), "rand");
        end

        // Flush during CALC of a DIV.
        @(negedge clk);
        bus.funct3_in = 3'd4; bus.word_op_in = 1'b0;
        bus.rs1_value_in = 64'd1000; bus.rs2_value_in = 64'd3;
        bus.start_in = 1'b1;
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.flush_in = 1'b1;
        @(posedge clk); #1;
        bus.flush_in = 1'b0;
        check("flush_busy", 64'(bus.busy_out), 64'd0);
        check("flush_result", bus.result_out, last_exp);
        done_seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            done_seen |= bus.done_out | bus.busy_out;
        end
        check("flush_no_done", 64'(done_seen), 64'd0);

        // Flush and start together in IDLE: flush wins.
        @(negedge clk);
        bus.start_in = 1'b1; bus.flush_in = 1'b1;
        @(posedge clk); #1;
        bus.start_in = 1'b0; bus.flush_in = 1'b0;
        check("flush_start_busy", 64'(bus.busy_out), 64'd0);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        bus.funct3_in = 3'd0; bus.word_op_in = 1'b0;
        bus.rs1_value_in = {$urandom, $urandom};
        bus.rs2_value_in = {$urandom, $urandom};
        bus.start_in = 1'b1;
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_result", bus.result_out, 64'd0);
        check("arst_busy", 64'(bus.busy_out), 64'd0);
        check("arst_done", 64'(bus.done_out), 64'd0);
        check("arst_stall", 64'(bus.stall_signal_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd0, 0, 64'd3, 64'd4, "mul_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
